pixel_bilinear_filt: RTL

Bilinear interpolation stage that sits directly downstream of the block-filter pixel reader. It pops one entry per cycle from the reader's output FIFO. Each entry holds four RGB565 neighbours {LT,RT,LB,RB} plus a 16-bit fractional weight word. For each entry it emits one blended RGB565 pixel toward the rotated-frame write FIFO. The datapath is fully pipelined at one pixel per clock, with FIFO-style backpressure on both sides.

---
 rtl/pixel_filt_pkg.sv | 21 ++
 rtl/filt_lerp.sv | 24 ++
 rtl/pixel_bilinear_filt.sv | 94 +++++++++
 3 files changed

// File: rtl/pixel_filt_pkg.sv
// Shared RGB565 / fractional-weight definitions for the block-filter reader and bilinear stage.
package pixel_filt_pkg;
   localparam int R_W          = 5;
   localparam int G_W          = 6;
   localparam int B_W          = 5;
   localparam int PIX_W        = R_W + G_W + B_W;
   localparam int FRAC_W       = 8;
   localparam int FILT_LATENCY = 4;

   // Neighbour positions inside the 64-bit {LT,RT,LB,RB} word
   localparam int LT_LSB = 3 * PIX_W;
   localparam int RT_LSB = 2 * PIX_W;
   localparam int LB_LSB = 1 * PIX_W;
   localparam int RB_LSB = 0;

   typedef struct packed {
      logic [R_W-1:0] r;
      logic [G_W-1:0] g;
      logic [B_W-1:0] b;
   } rgb565_t;
endpackage

// File: rtl/filt_lerp.sv
// Registered two-point blend q = a*(2^W - w) + b*w for one colour channel.
module filt_lerp #(
   parameter int CW = 5,
   parameter int W  = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [CW-1:0]   a,
   input  logic [CW-1:0]   b,
   input  logic [W-1:0]    w,
   output logic [CW+W-1:0] q
);
   localparam int QW = CW + W;

   logic [W:0] wc;

   // w = 0 yields the full weight 2^W; the two weights always sum to 2^W, so q never overflows QW bits
   assign wc = {1'b1, {W{1'b0}}} - {1'b0, w};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) q <= '0;
      else     q <= QW'(a) * QW'(wc) + QW'(b) * QW'(w);
   end
endmodule

// File: rtl/pixel_bilinear_filt.sv
// Bilinear RGB565 blend of {LT,RT,LB,RB} per FIFO entry, one pixel per clock, rd_en -> out_pixel_en in 4 cycles.
// Define PIXEL_BILINEAR_ROUND_EN for round-half-up normalisation; otherwise the result is truncated.
module pixel_bilinear_filt
   import pixel_filt_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          in_fifo_empty,
   output logic          in_fifo_rd_en,
   input  logic [63:0]   in_fifo_pixel,
   input  logic [15:0]   in_fifo_decimal,
   input  logic          out_fifo_almost_full,
   output logic [15:0]   out_pixel,
   output logic          out_pixel_en,
   output logic          busy
);
   localparam int RH = R_W + FRAC_W;
   localparam int GH = G_W + FRAC_W;
   localparam int BH = B_W + FRAC_W;
   localparam int RA = R_W + 2 * FRAC_W;
   localparam int GA = G_W + 2 * FRAC_W;
   localparam int BA = B_W + 2 * FRAC_W;

   logic [FILT_LATENCY-1:0] v;
   rgb565_t                 lt, rt, lb, rb;
   logic [FRAC_W-1:0]       fx, fy, fy_d;
   logic [RH-1:0]           top_r, bot_r;
   logic [GH-1:0]           top_g, bot_g;
   logic [BH-1:0]           top_b, bot_b;
   logic [RA-1:0]           acc_r, sum_r;
   logic [GA-1:0]           acc_g, sum_g;
   logic [BA-1:0]           acc_b, sum_b;
   logic                    unused_lsb;

   // No stall path: downstream headroom absorbs everything already in flight
   assign in_fifo_rd_en = !rst && !in_fifo_empty && !out_fifo_almost_full;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) v <= '0;
      else     v <= {v[FILT_LATENCY-2:0], in_fifo_rd_en};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lt <= '0;
         rt <= '0;
         lb <= '0;
         rb <= '0;
         fx <= '0;
         fy <= '0;
      end else if (v[0]) begin
         lt <= in_fifo_pixel[LT_LSB +: PIX_W];
         rt <= in_fifo_pixel[RT_LSB +: PIX_W];
         lb <= in_fifo_pixel[LB_LSB +: PIX_W];
         rb <= in_fifo_pixel[RB_LSB +: PIX_W];
         fx <= in_fifo_decimal[2*FRAC_W-1:FRAC_W];
         fy <= in_fifo_decimal[FRAC_W-1:0];
      end
   end

   // fy travels alongside the horizontal stage so it lines up with top/bot
   always_ff @(posedge clk or posedge rst) begin
      if (rst) fy_d <= '0;
      else     fy_d <= fy;
   end

   filt_lerp #(.CW(R_W), .W(FRAC_W)) u_top_r (.clk(clk), .rst(rst), .a(lt.r), .b(rt.r), .w(fx), .q(top_r));
   filt_lerp #(.CW(R_W), .W(FRAC_W)) u_bot_r (.clk(clk), .rst(rst), .a(lb.r), .b(rb.r), .w(fx), .q(bot_r));
   filt_lerp #(.CW(G_W), .W(FRAC_W)) u_top_g (.clk(clk), .rst(rst), .a(lt.g), .b(rt.g), .w(fx), .q(top_g));
   filt_lerp #(.CW(G_W), .W(FRAC_W)) u_bot_g (.clk(clk), .rst(rst), .a(lb.g), .b(rb.g), .w(fx), .q(bot_g));
   filt_lerp #(.CW(B_W), .W(FRAC_W)) u_top_b (.clk(clk), .rst(rst), .a(lt.b), .b(rt.b), .w(fx), .q(top_b));
   filt_lerp #(.CW(B_W), .W(FRAC_W)) u_bot_b (.clk(clk), .rst(rst), .a(lb.b), .b(rb.b), .w(fx), .q(bot_b));

   filt_lerp #(.CW(RH), .W(FRAC_W)) u_vert_r (.clk(clk), .rst(rst), .a(top_r), .b(bot_r), .w(fy_d), .q(acc_r));
   filt_lerp #(.CW(GH), .W(FRAC_W)) u_vert_g (.clk(clk), .rst(rst), .a(top_g), .b(bot_g), .w(fy_d), .q(acc_g));
   filt_lerp #(.CW(BH), .W(FRAC_W)) u_vert_b (.clk(clk), .rst(rst), .a(top_b), .b(bot_b), .w(fy_d), .q(acc_b));

`ifdef PIXEL_BILINEAR_ROUND_EN
   localparam int RND = 1 << (2 * FRAC_W - 1);
   assign sum_r = acc_r + RA'(RND);
   assign sum_g = acc_g + GA'(RND);
   assign sum_b = acc_b + BA'(RND);
`else
   assign sum_r = acc_r;
   assign sum_g = acc_g;
   assign sum_b = acc_b;
`endif

   // Weights total 2^16, so the top bits are already within channel range
   assign out_pixel    = {sum_r[RA-1:2*FRAC_W], sum_g[GA-1:2*FRAC_W], sum_b[BA-1:2*FRAC_W]};
   assign unused_lsb   = ^{sum_r[2*FRAC_W-1:0], sum_g[2*FRAC_W-1:0], sum_b[2*FRAC_W-1:0]};
   assign out_pixel_en = v[FILT_LATENCY-1];
   assign busy         = |v;
endmodule
